// File: rtl/eep_arb_ctrl.sv
// eep_arb_ctrl
// Shares the single calibration EEPROM port between two requesters:
// - the datapath coefficient fetch, which only reads
// - the SPI host command path, which reads and writes
// It sequences chip-select, read/write and charge-pump timing for both.
//
// Optional feature: define EEP_WR_VERIFY_EN to add a read-back verify after
// every write. A mismatch is reported on host_err together with host_ack.
//
// Ports:
//   clk, rst           system clock; synchronous active-high reset
//   dp_req/dp_addr     datapath read request (level, held until dp_ack)
//   dp_ack/dp_rd_data  one-cycle completion pulse; read data held until the
//                      next datapath read completes
//   host_req/host_wr/host_addr/host_wdata
//                      host request (level, held until host_ack)
//   host_ack/host_rd_data/host_err
//                      one-cycle completion pulse, held read data, and the
//                      verify error flag
//   eep_addr/eep_cs_n/eep_r_w_n/chrg_pmp_en/dst/eep_rd_data
//                      EEPROM pins
//   busy               high whenever the controller is not in IDLE
//   dbg_state          current FSM state, for observation only
//
// Handshake: a requester raises req and holds it, with its address and data,
// until it sees a one-cycle ack. It must drop req in the cycle after ack.
// Fields are latched at grant, so they are don't-care after that.
module eep_arb_ctrl #(
  parameter int RD_LAT   = 2,  // read cycles with cs low (>=1, <=256)
  parameter int PUMP_CYC = 3,  // charge-pump pre-charge cycles (>=1, <=256)
  parameter int WR_CYC   = 4   // write strobe cycles (>=1, <=256)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dp_req,
  input  logic [1:0]  dp_addr,
  output logic        dp_ack,
  output logic [11:0] dp_rd_data,
  input  logic        host_req,
  input  logic        host_wr,
  input  logic [1:0]  host_addr,
  input  logic [11:0] host_wdata,
  output logic        host_ack,
  output logic [11:0] host_rd_data,
  output logic        host_err,
  output logic [1:0]  eep_addr,
  output logic        eep_cs_n,
  output logic        eep_r_w_n,
  output logic        chrg_pmp_en,
  output logic [11:0] dst,
  input  logic [11:0] eep_rd_data,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {IDLE, RD, PUMP, WR, VRFY, DONE} state_t;

  // Phase counters load "length - 1" and count down to zero.
  localparam logic [7:0] RD_LAST   = 8'(RD_LAT - 1);
  localparam logic [7:0] PUMP_LAST = 8'(PUMP_CYC - 1);
  localparam logic [7:0] WR_LAST   = 8'(WR_CYC - 1);

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic        last_cyc;
  logic        gnt_host, gnt_dp;
  // The requester being served is also the last one granted, so a single
  // register serves both as the ack selector and as last_gnt (0 = dp).
  logic        gnt_host_q;
  logic [1:0]  addr_q;
  logic [11:0] wdata_q;

  assign last_cyc = (cnt == 8'd0);

  // On a tie, grant whoever was not granted last.
  assign gnt_host = (state == IDLE) && host_req && (!dp_req || !gnt_host_q);
  assign gnt_dp   = (state == IDLE) && dp_req && !gnt_host;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (gnt_host && host_wr) begin
          state_n = PUMP;
          cnt_n   = PUMP_LAST;
        end else if (gnt_host || gnt_dp) begin
          state_n = RD;
          cnt_n   = RD_LAST;
        end
      end
      RD: begin
        if (last_cyc) state_n = DONE;
        else          cnt_n   = cnt - 8'd1;
      end
      PUMP: begin
        if (last_cyc) begin
          state_n = WR;
          cnt_n   = WR_LAST;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      WR: begin
        if (last_cyc) begin
`ifdef EEP_WR_VERIFY_EN
          state_n = VRFY;
          cnt_n   = RD_LAST;
`else
          state_n = DONE;
`endif
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
`ifdef EEP_WR_VERIFY_EN
      VRFY: begin
        if (last_cyc) state_n = DONE;
        else          cnt_n   = cnt - 8'd1;
      end
`endif
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

`ifdef EEP_WR_VERIFY_EN
  logic err_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_host_q   <= 1'b0;
      addr_q       <= 2'd0;
      wdata_q      <= 12'd0;
      dst          <= 12'd0;
      dp_rd_data   <= 12'd0;
      host_rd_data <= 12'd0;
`ifdef EEP_WR_VERIFY_EN
      err_q        <= 1'b0;
`endif
    end else begin
      if (gnt_host) begin
        gnt_host_q <= 1'b1;
        addr_q     <= host_addr;
        wdata_q    <= host_wdata;
`ifdef EEP_WR_VERIFY_EN
        err_q      <= 1'b0;
`endif
      end else if (gnt_dp) begin
        gnt_host_q <= 1'b0;
        addr_q     <= dp_addr;
      end
      // Capture straight into the requester's output register on the last
      // RD cycle so the data is already valid in the DONE (ack) cycle.
      if (state == RD && last_cyc) begin
        if (gnt_host_q) host_rd_data <= eep_rd_data;
        else            dp_rd_data   <= eep_rd_data;
      end
      // dst is loaded at the PUMP->WR edge and then holds until the next write.
      if (state == PUMP && last_cyc) dst <= wdata_q;
`ifdef EEP_WR_VERIFY_EN
      if (state == VRFY && last_cyc) err_q <= (eep_rd_data != wdata_q);
`endif
    end
  end

  assign eep_addr    = addr_q;
  assign eep_cs_n    = !(state == RD || state == WR || state == VRFY);
  assign eep_r_w_n   = (state != WR);
  assign chrg_pmp_en = (state == PUMP || state == WR);
  assign busy        = (state != IDLE);
  assign dp_ack      = (state == DONE) && !gnt_host_q;
  assign host_ack    = (state == DONE) && gnt_host_q;
  assign dbg_state   = state;

`ifdef EEP_WR_VERIFY_EN
  assign host_err = host_ack && err_q;
`else
  assign host_err = 1'b0;
`endif

endmodule
